// File: rtl/z_pkg.sv
// z_pkg: shared definitions for the Z-code consumers.
//   Z_CODE_0..Z_CODE_3 : the four legal encoder codes (3 * state)
//   state_t            : window accumulator FSM states
package z_pkg;

  localparam logic [3:0] Z_CODE_0 = 4'd0;
  localparam logic [3:0] Z_CODE_1 = 4'd3;
  localparam logic [3:0] Z_CODE_2 = 4'd6;
  localparam logic [3:0] Z_CODE_3 = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : z_pkg

// File: rtl/z_code_check.sv
// z_code_check: combinational decoder for the 4-bit Z code.
// Ports:
//   Z     in  4  encoder code
//   legal out 1  Z is one of 0,3,6,9
//   sym   out 2  Z/3 for legal codes, 0 otherwise
module z_code_check
  import z_pkg::*;
(
  input  logic [3:0] Z,
  output logic       legal,
  output logic [1:0] sym
);

  always_comb begin
    legal = 1'b1;
    sym   = 2'd0;
    case (Z)
      Z_CODE_0: sym = 2'd0;
      Z_CODE_1: sym = 2'd1;
      Z_CODE_2: sym = 2'd2;
      Z_CODE_3: sym = 2'd3;
      default:  legal = 1'b0;
    endcase
  end

endmodule : z_code_check

// File: rtl/z_window_accumulator.sv
// z_window_accumulator: sums SAMPLES legal Z codes into one saturating window
// total and hands it out over a valid/ready handshake.
// Ports:
//   clk       in  1      rising-edge clock
//   reset     in  1      asynchronous active-low reset
//   Z         in  4      encoder code, sampled when z_valid=1
//   z_valid   in  1      Z is meaningful this cycle
//   start     in  1      begin a new window (IDLE only)
//   sum       out SUM_W  window total, stable while sum_valid=1
//   sum_valid out 1      total available
//   sum_ready in  1      consumer accepts total
//   busy      out 1      FSM is in ACCUM or DONE
//   code_err  out 1      sticky: illegal Z seen this window
//   sat       out 1      sticky: accumulator clipped this window
module z_window_accumulator
  import z_pkg::*;
#(
  parameter int SAMPLES = 4,
  parameter int SUM_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Z,
  input  logic             z_valid,
  input  logic             start,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             busy,
  output logic             code_err,
  output logic             sat
);

  // A single-sample window still needs a 1-bit counter to stay legal.
  localparam int CNT_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES - 1);

  state_t           state_reg, state_next;
  logic [SUM_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [SUM_W-1:0] sum_reg, sum_next;
  logic             code_err_reg, code_err_next;
  logic             sat_reg, sat_next;

  logic             legal;
  logic [1:0]       sym;
  logic [SUM_W:0]   addend;
  logic [SUM_W:0]   sum_wide;
  logic             add_ovf;
  logic [SUM_W-1:0] add_clamped;

  z_code_check u_code_check (
    .Z     (Z),
    .legal (legal),
    .sym   (sym)
  );

  // Rebuild the addend from the decoded symbol (3*sym) so only legal
  // magnitudes can ever reach the adder.
  assign addend      = (SUM_W + 1)'({sym, 1'b0}) + (SUM_W + 1)'(sym);
  assign sum_wide    = {1'b0, acc_reg} + addend;
  assign add_ovf     = sum_wide[SUM_W];
  assign add_clamped = add_ovf ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      acc_reg      <= '0;
      count_reg    <= '0;
      sum_reg      <= '0;
      code_err_reg <= 1'b0;
      sat_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      count_reg    <= count_next;
      sum_reg      <= sum_next;
      code_err_reg <= code_err_next;
      sat_reg      <= sat_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    count_next    = count_reg;
    sum_next      = sum_reg;
    code_err_next = code_err_reg;
    sat_next      = sat_reg;

    case (state_reg)
      ST_IDLE: begin
        // Any z_valid arriving with start belongs to no window yet.
        if (start) begin
          state_next    = ST_ACCUM;
          acc_next      = '0;
          count_next    = '0;
          code_err_next = 1'b0;
          sat_next      = 1'b0;
        end
      end

      ST_ACCUM: begin
        if (z_valid) begin
          if (!legal) begin
            code_err_next = 1'b1;
          end else begin
            acc_next = add_clamped;
            if (add_ovf) begin
              sat_next = 1'b1;
            end
            if (count_reg == LAST_CNT) begin
              state_next = ST_DONE;
              sum_next   = add_clamped;
              count_next = '0;
            end else begin
              count_next = count_reg + CNT_W'(1);
            end
          end
        end
      end

      ST_DONE: begin
        if (sum_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign sum       = sum_reg;
  assign sum_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg != ST_IDLE);
  assign code_err  = code_err_reg;
  assign sat       = sat_reg;

endmodule : z_window_accumulator

// File: tb/tb_z_window_accumulator.sv
module tb_z_window_accumulator;

  logic       clk;
  logic       reset;

  // Default instance: SAMPLES=4, SUM_W=8
  logic [3:0] Z;
  logic       z_valid;
  logic       start;
  logic [7:0] sum;
  logic       sum_valid;
  logic       sum_ready;
  logic       busy;
  logic       code_err;
  logic       sat;

  // Narrow instance: SAMPLES=2, SUM_W=4
  logic [3:0] z2;
  logic       z2_valid;
  logic       start2;
  logic [3:0] sum2;
  logic       sum2_valid;
  logic       ready2;
  logic       busy2;
  logic       code_err2;
  logic       sat2;

  int checks = 0;
  int errors = 0;

  z_window_accumulator #(.SAMPLES(4), .SUM_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .Z         (Z),
    .z_valid   (z_valid),
    .start     (start),
    .sum       (sum),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .busy      (busy),
    .code_err  (code_err),
    .sat       (sat)
  );

  z_window_accumulator #(.SAMPLES(2), .SUM_W(4)) dut_s (
    .clk       (clk),
    .reset     (reset),
    .Z         (z2),
    .z_valid   (z2_valid),
    .start     (start2),
    .sum       (sum2),
    .sum_valid (sum2_valid),
    .sum_ready (ready2),
    .busy      (busy2),
    .code_err  (code_err2),
    .sat       (sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus from a negedge; return at the next negedge,
  // so outputs then reflect the posedge in between.
  task automatic cyc(input logic st, input logic zv, input logic [3:0] z);
    start   = st;
    z_valid = zv;
    Z       = z;
    @(negedge clk);
  endtask

  task automatic cyc2(input logic st, input logic zv, input logic [3:0] z);
    start2   = st;
    z2_valid = zv;
    z2       = z;
    @(negedge clk);
  endtask

  task automatic test_reset;
    // Reset is asserted from time 0, before any clock edge.
    checks++;
    if ({sum_valid, busy, code_err, sat} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {sum_valid, busy, code_err, sat});
    end
    checks++;
    if (sum !== 8'd0) begin
      errors++;
      $display("FAIL reset_sum got %0d want 0", sum);
    end
    checks++;
    if ({sum2_valid, busy2, code_err2, sat2} !== 4'b0000 || sum2 !== 4'd0) begin
      errors++;
      $display("FAIL reset_narrow got flags %b sum %0d want 0000 0",
               {sum2_valid, busy2, code_err2, sat2}, sum2);
    end
    $display("reset: sum=%0d busy=%0b", sum, busy);
  endtask

  task automatic test_basic;
    cyc(1'b1, 1'b0, 4'd0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %0b want 1", busy);
    end
    cyc(1'b0, 1'b1, 4'd3);
    cyc(1'b0, 1'b1, 4'd6);
    cyc(1'b0, 1'b1, 4'd9);
    checks++;
    if (sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid got %0b want 0", sum_valid);
    end
    cyc(1'b0, 1'b1, 4'd0);
    checks++;
    if (sum_valid !== 1'b1 || sum !== 8'd18 || code_err !== 1'b0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got valid=%0b sum=%0d err=%0b sat=%0b want 1 18 0 0",
               sum_valid, sum, code_err, sat);
    end
    // sum_ready is held at 1, so the handshake completes on this edge.
    cyc(1'b0, 1'b0, 4'd0);
    checks++;
    if (sum_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'd18) begin
      errors++;
      $display("FAIL basic_release got valid=%0b busy=%0b sum=%0d want 0 0 18",
               sum_valid, busy, sum);
    end
    $display("window basic: sum=%0d code_err=%0b sat=%0b", sum, code_err, sat);
  endtask

  task automatic test_code_err;
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd3);
    cyc(1'b0, 1'b1, 4'd5);
    checks++;
    if (code_err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got err=%0b busy=%0b want 1 1", code_err, busy);
    end
    cyc(1'b0, 1'b1, 4'd6);
    cyc(1'b0, 1'b1, 4'd9);
    checks++;
    if (sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_illegal_counted got valid=%0b want 0", sum_valid);
    end
    cyc(1'b0, 1'b1, 4'd9);
    checks++;
    if (sum_valid !== 1'b1 || sum !== 8'd27 || code_err !== 1'b1) begin
      errors++;
      $display("FAIL err_result got valid=%0b sum=%0d err=%0b want 1 27 1",
               sum_valid, sum, code_err);
    end
    cyc(1'b0, 1'b0, 4'd0);
    $display("window code_err: sum=%0d code_err=%0b", sum, code_err);
  endtask

  task automatic test_saturation;
    cyc2(1'b1, 1'b0, 4'd0);
    cyc2(1'b0, 1'b1, 4'd9);
    checks++;
    if (sat2 !== 1'b0 || busy2 !== 1'b1 || sum2_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_first got sat=%0b busy=%0b valid=%0b want 0 1 0",
               sat2, busy2, sum2_valid);
    end
    cyc2(1'b0, 1'b1, 4'd9);
    checks++;
    if (sum2_valid !== 1'b1 || sum2 !== 4'd15 || sat2 !== 1'b1 || code_err2 !== 1'b0) begin
      errors++;
      $display("FAIL sat_result got valid=%0b sum=%0d sat=%0b err=%0b want 1 15 1 0",
               sum2_valid, sum2, sat2, code_err2);
    end
    cyc2(1'b0, 1'b0, 4'd0);
    $display("window sat: sum=%0d sat=%0b", sum2, sat2);
  endtask

  task automatic test_backpressure;
    sum_ready = 1'b0;
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd9);
    cyc(1'b0, 1'b1, 4'd9);
    cyc(1'b0, 1'b1, 4'd9);
    cyc(1'b0, 1'b1, 4'd9);
    for (int i = 0; i < 5; i++) begin
      // start and z_valid are both asserted but must be ignored in DONE.
      cyc(1'b1, 1'b1, 4'd3);
      checks++;
      if (sum_valid !== 1'b1 || sum !== 8'd36 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_%0d got valid=%0b sum=%0d busy=%0b want 1 36 1",
                 i, sum_valid, sum, busy);
      end
    end
    sum_ready = 1'b1;
    cyc(1'b1, 1'b0, 4'd0);
    checks++;
    if (sum_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got valid=%0b busy=%0b want 0 0", sum_valid, busy);
    end
    cyc(1'b0, 1'b0, 4'd0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_bypass got busy=%0b want 0", busy);
    end
    $display("window backpressure: sum=%0d", sum);
  endtask

  task automatic test_async_reset;
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd3);
    cyc(1'b0, 1'b1, 4'd5);
    cyc(1'b0, 1'b1, 4'd6);
    checks++;
    if (code_err !== 1'b1 || busy !== 1'b1 || sum !== 8'd36) begin
      errors++;
      $display("FAIL areset_pre got err=%0b busy=%0b sum=%0d want 1 1 36",
               code_err, busy, sum);
    end
    // Pull reset in the low clock phase: no rising edge occurs before the check.
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({sum_valid, busy, code_err, sat} !== 4'b0000 || sum !== 8'd0) begin
      errors++;
      $display("FAIL areset_outputs got flags %b sum %0d want 0000 0",
               {sum_valid, busy, code_err, sat}, sum);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd0);
    cyc(1'b0, 1'b1, 4'd0);
    cyc(1'b0, 1'b1, 4'd0);
    cyc(1'b0, 1'b1, 4'd3);
    checks++;
    if (sum_valid !== 1'b1 || sum !== 8'd3 || code_err !== 1'b0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL areset_fresh got valid=%0b sum=%0d err=%0b sat=%0b want 1 3 0 0",
               sum_valid, sum, code_err, sat);
    end
    cyc(1'b0, 1'b0, 4'd0);
    $display("window after reset: sum=%0d", sum);
  endtask

  task automatic test_gapped;
    // z_valid with start in IDLE is not a sample.
    cyc(1'b1, 1'b1, 4'd9);
    cyc(1'b0, 1'b1, 4'd3);
    cyc(1'b1, 1'b0, 4'd9);
    cyc(1'b1, 1'b1, 4'd9);
    cyc(1'b0, 1'b0, 4'd6);
    checks++;
    if (busy !== 1'b1 || sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_mid got busy=%0b valid=%0b want 1 0", busy, sum_valid);
    end
    cyc(1'b0, 1'b1, 4'd9);
    cyc(1'b1, 1'b0, 4'd3);
    checks++;
    if (sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_early got valid=%0b want 0", sum_valid);
    end
    cyc(1'b0, 1'b1, 4'd3);
    checks++;
    if (sum_valid !== 1'b1 || sum !== 8'd24) begin
      errors++;
      $display("FAIL gap_result got valid=%0b sum=%0d want 1 24", sum_valid, sum);
    end
    cyc(1'b0, 1'b0, 4'd0);
    $display("window gapped: sum=%0d", sum);
  endtask

  initial begin
    reset     = 1'b0;
    Z         = 4'd0;
    z_valid   = 1'b0;
    start     = 1'b0;
    sum_ready = 1'b1;
    z2        = 4'd0;
    z2_valid  = 1'b0;
    start2    = 1'b0;
    ready2    = 1'b1;
    #3;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_basic();
    test_code_err();
    test_saturation();
    test_backpressure();
    test_async_reset();
    test_gapped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_z_window_accumulator
